// File: rtl/sum_frame_pkg.sv
// Shared types and helpers for the frame accumulator.
package sum_frame_pkg;

  // Frame FSM: waiting for first sample, gathering, holding a result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Width of the saturating dropped-sample counter.
  localparam int DROP_W = 8;

  // Ceiling log2, used for the accumulator growth and the average shift.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sum_minmax_track.sv
// Running unsigned min/max tracker. The *_nxt_o outputs already include the
// sample being loaded/updated this cycle, so a caller can capture the final
// extremes on the same edge that accepts the last sample of a frame.
module sum_minmax_track #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             update_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] min_nxt_o,
  output logic [WIDTH-1:0] max_nxt_o
);

  logic [WIDTH-1:0] min_q, max_q;

  // Next extremes: load restarts from the sample, update folds it in.
  always_comb begin
    min_nxt_o = min_q;
    max_nxt_o = max_q;
    if (load_i) begin
      min_nxt_o = data_i;
      max_nxt_o = data_i;
    end else if (update_i) begin
      if (data_i < min_q) min_nxt_o = data_i;
      if (data_i > max_q) max_nxt_o = data_i;
    end
  end

  // Hold the running extremes between samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_nxt_o;
      max_q <= max_nxt_o;
    end
  end

endmodule

// File: rtl/sum_frame_accum.sv
// Frame accumulator: gathers FRAME_LEN samples from the adder stage and
// presents total/average/min/max on a valid/ready result port.
// Handshakes: a sample moves when in_valid && in_ready at a rising CLK edge;
// a result moves when out_valid && out_ready at a rising CLK edge. Upstream
// never stalls, so in_valid while in_ready is low is a lost sample.
module sum_frame_accum
  import sum_frame_pkg::*;
#(
  parameter  int WIDTH     = 3,
  parameter  int FRAME_LEN = 8,
  localparam int SHIFT     = clog2(FRAME_LEN),
  localparam int SW        = WIDTH + 1,
  localparam int ACC_W     = WIDTH + 1 + SHIFT
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [SW-1:0]     in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [SW-1:0]     out_avg,
  output logic [SW-1:0]     out_min,
  output logic [SW-1:0]     out_max,
  output logic [DROP_W-1:0] drop_cnt,
  output state_e            dbg_state
);

  localparam int CNT_W = SHIFT + 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [ACC_W-1:0]    sum_q;
  logic [SW-1:0]       avg_q, min_q, max_q;
  logic [SW-1:0]       min_nxt, max_nxt;
  logic                accept, load, update, capture;

  assign accept = in_valid && in_ready_q;

  sum_minmax_track #(.WIDTH(SW)) u_minmax (
    .clk       (CLK),
    .rst_n     (rst_n),
    .load_i    (load),
    .update_i  (update),
    .data_i    (in_data),
    .min_nxt_o (min_nxt),
    .max_nxt_o (max_nxt)
  );

  // Frame FSM next state, accumulator, handshake flags and drop counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    drop_d      = drop_q;
    load        = 1'b0;
    update      = 1'b0;
    capture     = 1'b0;
    if (clear) begin
      state_d     = IDLE;
      cnt_d       = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      drop_d      = '0;
    end else begin
      // in_ready is low only in HOLD or in the first cycle out of reset
      // (state IDLE); the latter is not counted as a drop.
      if (in_valid && !in_ready_q && state_q == HOLD && drop_q != '1)
        drop_d = drop_q + DROP_W'(1);
      unique case (state_q)
        IDLE: begin
          in_ready_d = 1'b1;
          if (accept) begin
            acc_d   = {{SHIFT{1'b0}}, in_data};
            cnt_d   = CNT_W'(1);
            load    = 1'b1;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_d  = acc_q + {{SHIFT{1'b0}}, in_data};
            cnt_d  = cnt_q + CNT_W'(1);
            update = 1'b1;
            if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
              capture     = 1'b1;
              out_valid_d = 1'b1;
              in_ready_d  = 1'b0;
              state_d     = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            cnt_d       = '0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and accumulation state.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
    end
  end

  // Result registers change only when a frame completes; clear leaves them.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      avg_q <= '0;
      min_q <= '0;
      max_q <= '0;
    end else if (capture) begin
      sum_q <= acc_d;
      avg_q <= acc_d[ACC_W-1:SHIFT];
      min_q <= min_nxt;
      max_q <= max_nxt;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_avg   = avg_q;
  assign out_min   = min_q;
  assign out_max   = max_q;
  assign drop_cnt  = drop_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sum_frame_accum.sv
// Bench for sum_frame_accum with WIDTH=3, FRAME_LEN=4 (ACC_W=6).
module tb_sum_frame_accum;
  import sum_frame_pkg::*;

  localparam int WIDTH = 3;
  localparam int FL    = 4;
  localparam int SW    = 4;
  localparam int ACC_W = 6;
  localparam int EW    = ACC_W + 3 * SW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic [SW-1:0]     in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ACC_W-1:0]  out_sum;
  logic [SW-1:0]     out_avg, out_min, out_max;
  logic [DROP_W-1:0] drop_cnt;
  state_e            dbg_state;

  sum_frame_accum #(.WIDTH(WIDTH), .FRAME_LEN(FL)) dut (
    .CLK       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_avg   (out_avg),
    .out_min   (out_min),
    .out_max   (out_max),
    .drop_cnt  (drop_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Bench-side frame model: samples accepted since the last frame boundary.
  int            cur_n = 0;
  int            cur_sum = 0;
  logic [SW-1:0] cur_min, cur_max;

  task automatic frame_reset();
    cur_n = 0;
    cur_sum = 0;
  endtask

  task automatic note_accept(input logic [SW-1:0] s);
    if (cur_n == 0) begin
      cur_min = s;
      cur_max = s;
    end else begin
      if (s < cur_min) cur_min = s;
      if (s > cur_max) cur_max = s;
    end
    cur_sum += s;
    cur_n++;
    if (cur_n == FL) begin
      logic [ACC_W-1:0] sum_v;
      logic [SW-1:0]    avg_v;
      sum_v = ACC_W'(cur_sum);
      avg_v = SW'(cur_sum / FL);
      exp_q.push_back({sum_v, avg_v, cur_min, cur_max});
      frame_reset();
    end
  endtask

  // Compare each delivered result against the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !clear) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", out_valid, 0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("out_sum", out_sum, e[EW-1 -: ACC_W]);
        check("out_avg", out_avg, e[3*SW-1 -: SW]);
        check("out_min", out_min, e[2*SW-1 -: SW]);
        check("out_max", out_max, e[SW-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one sample and hold it until accepted (bounded).
  task automatic send(input logic [SW-1:0] s);
    bit acc;
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = s;
    do begin
      acc = in_ready;
      if (guard > 3) out_ready = 1'b1;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check("send_timeout", acc, 1);
    else note_accept(s);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_sum"},   out_sum, 0);
    check({tag, "_out_avg"},   out_avg, 0);
    check({tag, "_out_min"},   out_min, 0);
    check({tag, "_out_max"},   out_max, 0);
    check({tag, "_drop_cnt"},  drop_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset with a sample already offered: the first edge must not count it.
    in_valid = 1'b1;
    in_data  = 4'd1;
    #12;
    check_zero_outputs("reset");
    #11 rst_n = 1'b1;                      // release between edges
    #1 check("rel_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    check("rel_in_ready_high", in_ready, 1);
    check("rel_drop_cnt", drop_cnt, 0);
    check("rel_state", dbg_state, IDLE);

    // Back-to-back 1,2,3,4 with consumer ready.
    send(4'd1); send(4'd2); send(4'd3); send(4'd4);
    in_valid = 1'b0;
    check("s1_out_valid", out_valid, 1);
    check("s1_in_ready", in_ready, 0);
    check("s1_state", dbg_state, HOLD);
    step(1);
    check("s1_valid_one_cycle", out_valid, 0);
    check("s1_in_ready_back", in_ready, 1);
    check("s1_drop", drop_cnt, 0);

    // Max-valued samples with bubbles between them.
    for (int i = 0; i < FL; i++) begin
      send(4'd15);
      in_valid = 1'b0;
      step(1);
    end
    check("s2_drop", drop_cnt, 0);
    check("s2_in_ready", in_ready, 1);

    // Consumer stalls 3 cycles while upstream keeps offering.
    out_ready = 1'b0;
    send(4'd5); send(4'd1); send(4'd7); send(4'd2);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("s3_valid_held", out_valid, 1);
      check("s3_sum_stable", out_sum, 15);
      check("s3_max_stable", out_max, 7);
    end
    check("s3_drop", drop_cnt, 3);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(1);
    check("s3_in_ready_after", in_ready, 1);
    check("s3_valid_after", out_valid, 0);
    check("s3_drop_kept", drop_cnt, 3);

    // Partial frame flushed by clear.
    send(4'd9); send(4'd9);
    in_valid = 1'b0;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    frame_reset();
    check("s4_drop_cleared", drop_cnt, 0);
    check("s4_in_ready", in_ready, 1);
    check("s4_state", dbg_state, IDLE);
    check("s4_sum_retained", out_sum, 15);
    send(4'd0); send(4'd0); send(4'd0); send(4'd8);
    in_valid = 1'b0;
    check("s4_drop_end", drop_cnt, 0);
    step(1);

    // Asynchronous reset while holding a result.
    out_ready = 1'b0;
    send(4'd3); send(4'd3); send(4'd3); send(4'd3);
    in_valid = 1'b0;
    check("s5_hold", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("s5_async");
    check("s5_state", dbg_state, IDLE);
    exp_q.delete();
    frame_reset();
    out_ready = 1'b1;
    step(2);
    #3 rst_n = 1'b1;
    #1 check("s5_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    check("s5_in_ready_high", in_ready, 1);

    // Drop counter saturation, then clear together with out_ready.
    out_ready = 1'b0;
    send(4'd1); send(4'd1); send(4'd1); send(4'd1);
    in_valid = 1'b1;
    step(300);
    check("s6_drop_sat", drop_cnt, 255);
    check("s6_valid_held", out_valid, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clear     = 1'b1;
    step(1);
    clear = 1'b0;
    void'(exp_q.pop_front());             // clear wins: result not delivered
    check("s6_drop_cleared", drop_cnt, 0);
    check("s6_valid_dropped", out_valid, 0);
    check("s6_in_ready", in_ready, 1);
    check("s6_sum_retained", out_sum, 4);

    // Random frames with random bubbles and consumer back-pressure.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < FL; i++) begin
        out_ready = 1'($urandom_range(0, 1));
        send(SW'($urandom_range(0, 15)));
        if ($urandom_range(0, 1) == 1) begin
          in_valid = 1'b0;
          step($urandom_range(1, 2));
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(4);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
